// File: rtl/ysyx_25020037_issue_ctrl.sv
// rtl/ysyx_25020037_issue_ctrl.sv - IDU->EXU issue control with load-use interlock, redirect flush and fence.i drain (optional perf counters: YSYX_25020037_ISSUE_PERF_EN)
module ysyx_25020037_issue_ctrl #(
    parameter int NREG         = 16,
    parameter int CNT_W        = 2,
    parameter int INFLIGHT_MAX = 4,
    parameter int INF_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idu_valid,
    output logic             idu_ready,
    input  logic [3:0]       rs1,
    input  logic [3:0]       rs2,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [3:0]       rd,
    input  logic             gpr_we,
    input  logic             inst_l,
    input  logic             is_fence_i,
    input  logic             exu_ready,
    output logic             issue_valid,
    input  logic             wbu_valid,
    input  logic             wbu_we,
    input  logic             wbu_is_load,
    input  logic [3:0]       wbu_rd,
    input  logic             redirect_valid,
    input  logic             pc_updata,
    output logic [INF_W-1:0] inflight_cnt,
`ifdef YSYX_25020037_ISSUE_PERF_EN
    output logic [31:0]      perf_lu_stall,
    output logic [31:0]      perf_flush_drop,
`endif
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   pend_cnt [NREG];
    logic [CNT_W-1:0]   load_cnt [NREG];
    logic [INF_W-1:0]   inflight_n;
    logic               lu_hazard;
    logic               hazard;
    logic               issue_valid_c;
    logic               idu_ready_c;
    logic               fire;

    // A source only stalls while a load to it is still outstanding; ALU results come via bypass.
    assign lu_hazard = (rs1_used && (rs1 != 4'd0) && (load_cnt[rs1] != '0)) ||
                       (rs2_used && (rs2 != 4'd0) && (load_cnt[rs2] != '0));
    assign hazard    = lu_hazard ||
                       (gpr_we && (rd != 4'd0) && (pend_cnt[rd] == CNT_MAX)) ||
                       (inflight_cnt == INF_W'(INFLIGHT_MAX));

    // Outputs are forced low while reset is held so they drop asynchronously with it.
    assign issue_valid  = rst & issue_valid_c;
    assign idu_ready    = rst & idu_ready_c;
    assign fire         = issue_valid & exu_ready;
    assign state_o      = state;

    // Next in-flight count; simultaneous issue and commit cancel out.
    always_comb begin
        inflight_n = inflight_cnt;
        if (fire && !wbu_valid) begin
            inflight_n = inflight_cnt + 1'b1;
        end else if (!fire && wbu_valid && (inflight_cnt != '0)) begin
            inflight_n = inflight_cnt - 1'b1;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_n       = state;
        issue_valid_c = 1'b0;
        idu_ready_c   = 1'b0;
        case (state)
            ST_RUN: begin
                issue_valid_c = idu_valid && !hazard;
                idu_ready_c   = issue_valid_c && exu_ready;
                if (redirect_valid) begin
                    state_n = ST_FLUSH;
                end else if (idu_ready_c && is_fence_i) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                idu_ready_c = idu_valid;
                if (pc_updata) begin
                    state_n = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    state_n = ST_FLUSH;
                end else if (inflight_n == '0) begin
                    state_n = ST_RUN;
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    // State and in-flight count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_RUN;
            inflight_cnt <= '0;
        end else begin
            state        <= state_n;
            inflight_cnt <= inflight_n;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        logic             pend_inc;
        logic             pend_dec;
        logic             load_inc;
        logic             load_dec;
        logic [CNT_W-1:0] pend_q;
        logic [CNT_W-1:0] load_q;

        assign pend_inc    = fire && gpr_we && (rd == 4'(g)) && (g != 0);
        assign pend_dec    = wbu_valid && wbu_we && (wbu_rd == 4'(g)) && (g != 0);
        assign load_inc    = pend_inc && inst_l;
        assign load_dec    = pend_dec && wbu_is_load;
        assign pend_cnt[g] = pend_q;
        assign load_cnt[g] = load_q;

        // Per-register outstanding-write and outstanding-load counters; saturate, never wrap.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pend_q <= '0;
                load_q <= '0;
            end else begin
                if (pend_inc && !pend_dec && (pend_q != CNT_MAX)) begin
                    pend_q <= pend_q + 1'b1;
                end else if (pend_dec && !pend_inc && (pend_q != '0)) begin
                    pend_q <= pend_q - 1'b1;
                end
                if (load_inc && !load_dec && (load_q != CNT_MAX)) begin
                    load_q <= load_q + 1'b1;
                end else if (load_dec && !load_inc && (load_q != '0)) begin
                    load_q <= load_q - 1'b1;
                end
            end
        end

        // A commit must never find its counter already empty.
        always_ff @(posedge clk) begin
            if (rst && pend_dec) begin
                assert (pend_q != '0);
            end
        end
    end

    // A commit with nothing in flight indicates an upstream protocol error.
    always_ff @(posedge clk) begin
        if (rst && wbu_valid) begin
            assert (inflight_cnt != '0);
        end
    end

`ifdef YSYX_25020037_ISSUE_PERF_EN
    // Load-use stall cycles and wrong-path drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lu_stall   <= '0;
            perf_flush_drop <= '0;
        end else begin
            if ((state == ST_RUN) && idu_valid && lu_hazard) begin
                perf_lu_stall <= perf_lu_stall + 32'd1;
            end
            if ((state == ST_FLUSH) && idu_valid) begin
                perf_flush_drop <= perf_flush_drop + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_25020037_issue_ctrl.sv
// tb/tb_ysyx_25020037_issue_ctrl.sv - directed and randomized checks of the issue controller against a queue-based model
module tb_ysyx_25020037_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       idu_valid, idu_ready;
    logic [3:0] rs1, rs2, rd, wbu_rd;
    logic       rs1_used, rs2_used, gpr_we, inst_l, is_fence_i, exu_ready;
    logic       issue_valid, wbu_valid, wbu_we, wbu_is_load, redirect_valid, pc_updata;
    logic [2:0] inflight_cnt;
    logic [1:0] state_o;
`ifdef YSYX_25020037_ISSUE_PERF_EN
    logic [31:0] perf_lu_stall, perf_flush_drop;
`endif

    ysyx_25020037_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .idu_valid(idu_valid), .idu_ready(idu_ready),
        .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd(rd), .gpr_we(gpr_we), .inst_l(inst_l), .is_fence_i(is_fence_i),
        .exu_ready(exu_ready), .issue_valid(issue_valid),
        .wbu_valid(wbu_valid), .wbu_we(wbu_we), .wbu_is_load(wbu_is_load), .wbu_rd(wbu_rd),
        .redirect_valid(redirect_valid), .pc_updata(pc_updata),
        .inflight_cnt(inflight_cnt),
`ifdef YSYX_25020037_ISSUE_PERF_EN
        .perf_lu_stall(perf_lu_stall), .perf_flush_drop(perf_flush_drop),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rd;
        bit we;
        bit ld;
    } ent_t;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    int   pend[16];
    int   lcnt[16];
    int   infl;
    int   st;
    int   m_lu;
    int   m_drop;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            pend[i] = 0;
            lcnt[i] = 0;
        end
        q.delete();
        infl   = 0;
        st     = 0;
        m_lu   = 0;
        m_drop = 0;
    endtask

    task automatic drive_idu(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                             input int d, input bit we, input bit l, input bit fi);
        idu_valid  = v;
        rs1        = 4'(r1);
        rs1_used   = u1;
        rs2        = 4'(r2);
        rs2_used   = u2;
        rd         = 4'(d);
        gpr_we     = we;
        inst_l     = l;
        is_fence_i = fi;
    endtask

    // Commits always retire the oldest issued instruction.
    task automatic drive_ctl(input bit er, input bit cm, input bit rdr, input bit pu);
        exu_ready      = er;
        redirect_valid = rdr;
        pc_updata      = pu;
        wbu_valid      = cm && (q.size() > 0);
        if (wbu_valid) begin
            wbu_rd      = 4'(q[0].rd);
            wbu_we      = q[0].we;
            wbu_is_load = q[0].ld;
        end else begin
            wbu_rd      = 4'd0;
            wbu_we      = 1'b0;
            wbu_is_load = 1'b0;
        end
    endtask

    // One clock: check handshakes, advance the model at the edge, check registered state.
    task automatic step();
        bit lu, hz, eiv, erdy, fire;
        ent_t e;
        #1;
        lu   = (rs1_used && rs1 != 0 && lcnt[rs1] > 0) || (rs2_used && rs2 != 0 && lcnt[rs2] > 0);
        hz   = lu || (gpr_we && rd != 0 && pend[rd] >= 3) || (infl >= 4);
        eiv  = (st == 0) && idu_valid && !hz;
        erdy = (st == 0) ? (eiv && exu_ready) : (st == 1) ? idu_valid : 1'b0;
        fire = eiv && exu_ready;
        chk("issue_valid", {31'd0, issue_valid}, {31'd0, eiv});
        chk("idu_ready", {31'd0, idu_ready}, {31'd0, erdy});
        @(posedge clk);
        if (st == 0 && idu_valid && lu) m_lu++;
        if (st == 1 && idu_valid) m_drop++;
        if (fire) begin
            infl++;
            q.push_back('{int'(rd), gpr_we && rd != 0, inst_l});
            if (gpr_we && rd != 0) begin
                pend[rd]++;
                if (inst_l) lcnt[rd]++;
            end
        end
        if (wbu_valid) begin
            e = q.pop_front();
            infl--;
            if (e.we) begin
                pend[e.rd]--;
                if (e.ld) lcnt[e.rd]--;
            end
        end
        case (st)
            0: if (redirect_valid) st = 1; else if (fire && is_fence_i) st = 2;
            1: if (pc_updata) st = 0;
            default: if (redirect_valid) st = 1; else if (infl == 0) st = 0;
        endcase
        @(negedge clk);
        chk("state", {30'd0, state_o}, 32'(st));
        chk("inflight", {29'd0, inflight_cnt}, 32'(infl));
`ifdef YSYX_25020037_ISSUE_PERF_EN
        chk("perf_lu_stall", perf_lu_stall, 32'(m_lu));
        chk("perf_flush_drop", perf_flush_drop, 32'(m_drop));
`endif
    endtask

    task automatic drain();
        drive_idu(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            drive_ctl(1, 1, 0, 0);
            step();
        end
        drive_ctl(1, 0, 0, 0);
        step();
        chk("drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        drive_idu(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_ctl(1, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", {30'd0, state_o}, 32'd0);
        chk("rst_inflight", {29'd0, inflight_cnt}, 32'd0);
        chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
        chk("rst_idu_ready", {31'd0, idu_ready}, 32'd0);
        rst = 1'b1;

        // Load-use on x5: stall until the load commits, issue the cycle after.
        drive_idu(1, 0, 0, 0, 0, 5, 1, 1, 0);
        step();
        drive_idu(1, 5, 1, 0, 0, 7, 1, 0, 0);
        step();
        step();
        chk("lu_stall_x5", {31'd0, issue_valid}, 32'd0);
        drive_ctl(1, 1, 0, 0);
        step();
        drive_ctl(1, 0, 0, 0);
        #1;
        chk("lu_release_x5", {31'd0, issue_valid}, 32'd1);
        step();
        drain();

        // ALU producer x6 followed by consumer: no stall.
        drive_idu(1, 0, 0, 0, 0, 6, 1, 0, 0);
        step();
        drive_idu(1, 0, 0, 6, 1, 0, 0, 0, 0);
        #1;
        chk("alu_no_stall", {31'd0, issue_valid}, 32'd1);
        step();
        drain();

        // In-flight limit of four.
        drive_idu(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) step();
        chk("inflight_full", {29'd0, inflight_cnt}, 32'd4);
        chk("fifth_held", {31'd0, issue_valid}, 32'd0);
        drive_ctl(1, 1, 0, 0);
        step();
        drive_ctl(1, 0, 0, 0);
        step();
        chk("fifth_issued", {29'd0, inflight_cnt}, 32'd4);
        drain();

        // Redirect, three wrong-path drops, then pc_updata.
        drive_idu(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_ctl(1, 0, 1, 0);
        step();
        drive_ctl(1, 0, 0, 0);
        drive_idu(1, 3, 1, 4, 1, 9, 1, 1, 0);
        repeat (3) step();
        chk("flush_no_count", {29'd0, inflight_cnt}, 32'd0);
        drive_idu(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_ctl(1, 0, 0, 1);
        step();
        chk("flush_exit", {30'd0, state_o}, 32'd0);
`ifdef YSYX_25020037_ISSUE_PERF_EN
        chk("flush_drop3", perf_flush_drop, 32'd3);
`endif
        drive_ctl(1, 0, 0, 0);

        // fence.i with two older instructions in flight.
        drive_idu(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step();
        drive_idu(1, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        chk("fence_drain", {30'd0, state_o}, 32'd2);
        chk("fence_inflight", {29'd0, inflight_cnt}, 32'd3);
        drive_idu(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_ctl(1, 1, 0, 0);
        repeat (3) step();
        chk("fence_run", {30'd0, state_o}, 32'd0);
        chk("fence_empty", {29'd0, inflight_cnt}, 32'd0);
        drive_ctl(1, 0, 0, 0);
        drain();

        // Asynchronous reset in the middle of DRAIN.
        drive_idu(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step();
        drive_idu(1, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        chk("pre_rst_drain", {30'd0, state_o}, 32'd2);
        drive_idu(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_state", {30'd0, state_o}, 32'd0);
        chk("async_inflight", {29'd0, inflight_cnt}, 32'd0);
        chk("async_issue_valid", {31'd0, issue_valid}, 32'd0);
        chk("async_idu_ready", {31'd0, idu_ready}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            drive_idu($urandom_range(0, 9) < 7,
                      $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 9) < 3, $urandom_range(0, 29) == 0);
            drive_ctl($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
                      $urandom_range(0, 24) == 0, $urandom_range(0, 9) < 3);
            step();
        end
        drive_ctl(1, 0, 0, 1);
        drive_idu(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25020037_issue_ctrl.md
Name: ysyx_25020037_issue_ctrl

Overview:
- Issue controller between IDU and EXU; decides each cycle whether the decoded instruction may enter EXU.
- Tracks in-flight register writes per architectural register (RV32E, 16 regs, 4-bit indices).
- Stalls load-use RAW hazards. Non-load results are covered by EXU bypass and are not stalled.
- Discards wrong-path instructions after an EXU redirect; drains the pipeline after fence.i.

Parameters:
- NREG, 16, number of architectural registers.
- CNT_W, 2, width of per-register pending counters (saturate at 2^CNT_W-1).
- INFLIGHT_MAX, 4, max instructions issued but not yet committed (matches EXU bypass depth).
- INF_W, 3, width of the in-flight counter; must hold INFLIGHT_MAX.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- idu_valid  in  1  IDU holds a decoded instruction
- idu_ready  out  1  IDU instruction consumed this cycle (issued or discarded)
- rs1, rs2  in  4 each  source register indices
- rs1_used, rs2_used  in  1 each  source actually read by the instruction
- rd  in  4  destination index
- gpr_we  in  1  instruction writes rd
- inst_l  in  1  instruction is a load
- is_fence_i  in  1  instruction is fence.i
- exu_ready  in  1  EXU accepts an instruction
- issue_valid  out  1  instruction presented to EXU
- wbu_valid  in  1  one instruction commits this cycle
- wbu_we, wbu_is_load  in  1 each  committing instruction wrote a GPR / was a load
- wbu_rd  in  4  committing destination index
- redirect_valid  in  1  EXU signals a taken redirect (exu_dnpc_valid)
- pc_updata  in  1  IFU has applied the redirect
- inflight_cnt  out  INF_W  issued-not-committed count
- state_o  out  2  FSM state: 0=RUN, 1=FLUSH, 2=DRAIN

Behaviour:
- Reset (rst=0, async): state RUN; all counters 0; issue_valid=0; idu_ready=0; inflight_cnt=0.
- hazard = (rs1_used & rs1!=0 & load_cnt[rs1]!=0) | (rs2_used & rs2!=0 & load_cnt[rs2]!=0) | (gpr_we & rd!=0 & pend_cnt[rd]==max) | (inflight_cnt==INFLIGHT_MAX).
- RUN: issue_valid = idu_valid & !hazard. fire = issue_valid & exu_ready. idu_ready = fire. Combinational, zero-cycle latency.
- On fire: inflight+1. If gpr_we & rd!=0, pend_cnt[rd]+1. If additionally inst_l, load_cnt[rd]+1.
- On wbu_valid: inflight-1. If wbu_we & wbu_rd!=0, pend_cnt[wbu_rd]-1. If additionally wbu_is_load, load_cnt[wbu_rd]-1.
- Fire and commit in the same cycle on the same counter: net unchanged. Counters never wrap; decrement at 0 is ignored and asserts in simulation.
- rd=0 never updates counters; reads of x0 never stall.
- FSM transitions:
  - RUN -> FLUSH on redirect_valid. Takes priority over fire-driven DRAIN in the same cycle; fire still counts.
  - RUN -> DRAIN on fire with is_fence_i.
  - FLUSH: issue_valid=0; idu_ready=idu_valid, so wrong-path instructions are dropped with no counter update. -> RUN on pc_updata.
  - DRAIN: issue_valid=0; idu_ready=0. -> RUN when inflight_cnt==0, or when next-cycle inflight reaches 0 via a commit. -> FLUSH on redirect_valid.
- Commits keep updating counters in all states.
- If pc_updata and redirect_valid are both high in FLUSH: go to RUN (pc_updata wins).

Optional Feature:
- Macro: YSYX_25020037_ISSUE_PERF_EN.
- Defined: adds output ports perf_lu_stall (32) and perf_flush_drop (32).
  - perf_lu_stall increments each cycle in RUN with idu_valid and a load-use hazard.
  - perf_flush_drop increments per instruction dropped in FLUSH.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Load x5 fires; next instr rs1=5 with exu_ready=1 -> issue_valid=0 until a commit with wbu_we=1, wbu_is_load=1, wbu_rd=5; issues the same cycle load_cnt[5] returns to 0.
- ALU write x6, then instr rs2=6 back-to-back -> second issues next cycle, no stall; pend_cnt[6]=1 then 0 after commit.
- Five independent instrs with no commits -> first four issue, inflight_cnt=4, fifth held with issue_valid=0; one wbu_valid -> fifth issues.
- redirect_valid pulse, then 3 IDU instrs, then pc_updata -> all 3 consumed with idu_ready=1, no counter change (perf_flush_drop=3 with macro), state back to RUN.
- fence.i fires with inflight_cnt=2 -> state DRAIN, no issue; after 2 commits plus fence.i commit, inflight_cnt=0 -> RUN next cycle.
- Assert rst=0 mid-DRAIN with inflight_cnt=3 -> outputs 0 and state RUN immediately, asynchronously.
